// File: rtl/command_arbiter.sv
// Per-channel command arbiter: CAS-first round-robin over the per-bank queue heads,
// with an ACT/PRE starvation guard and a one-entry valid/ready output register.

module command_arbiter_lane #(
    parameter int CMD_TYPE_WIDTH = 3,
    parameter int CMD_RD         = 3,
    parameter int CMD_WR         = 4
) (
    input  logic                      valid,
    input  logic                      timing_ok,
    input  logic [CMD_TYPE_WIDTH-1:0] cmd,
    output logic                      elig,
    output logic                      cas
);
    assign elig = valid & timing_ok;
    assign cas  = elig & ((cmd == CMD_TYPE_WIDTH'(CMD_RD)) | (cmd == CMD_TYPE_WIDTH'(CMD_WR)));
endmodule

module command_arbiter #(
    parameter int CMD_TYPE_WIDTH = 3,
    parameter int CH_WIDTH       = 1,
    parameter int RNK_WIDTH      = 1,
    parameter int BG_WIDTH       = 2,
    parameter int BNK_WIDTH      = 3,
    parameter int ROW_WIDTH      = 3,
    parameter int COL_WIDTH      = 6,
    parameter int DATA_PTR_WIDTH = 4,
    parameter int NUM_BNK_TOT    = 16,
    parameter int CMD_RD         = 3,
    parameter int CMD_WR         = 4,
    parameter int STARVE_LIMIT   = 8,
    localparam int IDX_W         = $clog2(NUM_BNK_TOT),
    localparam int SC_W          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [NUM_BNK_TOT-1:0]                       i_valid,
    input  logic [NUM_BNK_TOT-1:0][CMD_TYPE_WIDTH-1:0]   i_cmd,
    input  logic [NUM_BNK_TOT-1:0][CH_WIDTH-1:0]         i_channel,
    input  logic [NUM_BNK_TOT-1:0][RNK_WIDTH-1:0]        i_rank,
    input  logic [NUM_BNK_TOT-1:0][BG_WIDTH-1:0]         i_bank_group,
    input  logic [NUM_BNK_TOT-1:0][BNK_WIDTH-1:0]        i_bank,
    input  logic [NUM_BNK_TOT-1:0][ROW_WIDTH-1:0]        i_row,
    input  logic [NUM_BNK_TOT-1:0][COL_WIDTH-1:0]        i_column,
    input  logic [NUM_BNK_TOT-1:0][DATA_PTR_WIDTH-1:0]   i_data_ptr,
    input  logic [NUM_BNK_TOT-1:0]                       i_timing_ok,
    output logic [NUM_BNK_TOT-1:0]                       o_dequeue,
    output logic                                         o_cmd_valid,
    input  logic                                         i_cmd_ready,
    output logic [CMD_TYPE_WIDTH-1:0]                    o_cmd,
    output logic [CH_WIDTH-1:0]                          o_channel,
    output logic [RNK_WIDTH-1:0]                         o_rank,
    output logic [BG_WIDTH-1:0]                          o_bank_group,
    output logic [BNK_WIDTH-1:0]                         o_bank,
    output logic [ROW_WIDTH-1:0]                         o_row,
    output logic [COL_WIDTH-1:0]                         o_column,
    output logic [DATA_PTR_WIDTH-1:0]                    o_data_ptr,
    output logic [IDX_W-1:0]                             o_bank_idx,
    output logic                                         o_starve_active
);
    typedef struct packed {
        logic [CMD_TYPE_WIDTH-1:0] cmd;
        logic [CH_WIDTH-1:0]       ch;
        logic [RNK_WIDTH-1:0]      rnk;
        logic [BG_WIDTH-1:0]       bg;
        logic [BNK_WIDTH-1:0]      bnk;
        logic [ROW_WIDTH-1:0]      row;
        logic [COL_WIDTH-1:0]      col;
        logic [DATA_PTR_WIDTH-1:0] ptr;
    } head_t;

    head_t                  heads [NUM_BNK_TOT];
    head_t                  out_q;
    logic [NUM_BNK_TOT-1:0] elig, cas, sel_set;
    logic [IDX_W-1:0]       rr_ptr, winner;
    logic [IDX_W:0]         sum;
    logic [SC_W-1:0]        starve_cnt;
    logic                   found, grant, can_load, win_cas, noncas_pend, armed;

    for (genvar g = 0; g < NUM_BNK_TOT; g++) begin : g_lane
        command_arbiter_lane #(
            .CMD_TYPE_WIDTH(CMD_TYPE_WIDTH), .CMD_RD(CMD_RD), .CMD_WR(CMD_WR)
        ) u_lane (
            .valid(i_valid[g]), .timing_ok(i_timing_ok[g]), .cmd(i_cmd[g]),
            .elig(elig[g]), .cas(cas[g])
        );
        assign heads[g] = '{cmd: i_cmd[g], ch: i_channel[g], rnk: i_rank[g], bg: i_bank_group[g],
                            bnk: i_bank[g], row: i_row[g], col: i_column[g], ptr: i_data_ptr[g]};
    end

    assign o_starve_active = (starve_cnt == SC_W'(STARVE_LIMIT));
    assign can_load        = !o_cmd_valid | i_cmd_ready;
    assign noncas_pend     = |(elig & ~cas);
    assign win_cas         = cas[winner];
    // armed keeps the first cycle after reset release free of dequeue pulses
    assign grant           = armed & rstn & can_load & found;

    // Rotating priority scan starting at rr_ptr, wrapping modulo NUM_BNK_TOT
    always_comb begin
        sel_set = (|cas && !o_starve_active) ? cas : elig;
        found   = 1'b0;
        winner  = '0;
        sum     = '0;
        for (int i = 0; i < NUM_BNK_TOT; i++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_BNK_TOT))
                sum = sum - (IDX_W+1)'(NUM_BNK_TOT);
            if (!found && sel_set[sum[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        o_dequeue         = '0;
        o_dequeue[winner] = grant;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q       <= '0;
            o_cmd_valid <= 1'b0;
            o_bank_idx  <= '0;
            rr_ptr      <= '0;
            starve_cnt  <= '0;
            armed       <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (grant) begin
                out_q       <= heads[winner];
                o_bank_idx  <= winner;
                o_cmd_valid <= 1'b1;
                rr_ptr      <= (winner == IDX_W'(NUM_BNK_TOT - 1)) ? '0 : winner + 1'b1;
            end else if (o_cmd_valid && i_cmd_ready) begin
                o_cmd_valid <= 1'b0;
            end
            // Count CAS grants that bypassed a waiting ACT/PRE; saturate at the limit
            if ((grant && !win_cas) || !noncas_pend)
                starve_cnt <= '0;
            else if (grant && win_cas && !o_starve_active)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign o_cmd        = out_q.cmd;
    assign o_channel    = out_q.ch;
    assign o_rank       = out_q.rnk;
    assign o_bank_group = out_q.bg;
    assign o_bank       = out_q.bnk;
    assign o_row        = out_q.row;
    assign o_column     = out_q.col;
    assign o_data_ptr   = out_q.ptr;
endmodule
